// File: rtl/adder_seq_arbiter.sv
// adder_seq_arbiter: round-robin shares one N-bit adder for WORDS*N-bit adds, LSW first.
// Define ADDSEQ_SUB_EN to add per-requester subtract (A-B) support.
module adder_seq_arbiter #(
  parameter int N = 4,
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [N*WORDS-1:0]   req0_a,
  input  logic [N*WORDS-1:0]   req0_b,
  input  logic                 req0_ci,
  input  logic [N*WORDS-1:0]   req1_a,
  input  logic [N*WORDS-1:0]   req1_b,
  input  logic                 req1_ci,
`ifdef ADDSEQ_SUB_EN
  input  logic                 req0_sub,
  input  logic                 req1_sub,
`endif
  output logic [N-1:0]         add_a,
  output logic [N-1:0]         add_b,
  output logic                 add_ci,
  input  logic [N-1:0]         add_s,
  input  logic                 add_co,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic                 resp_id,
  output logic [N*WORDS-1:0]   resp_sum,
  output logic                 resp_co
);
  localparam int W = N * WORDS;
  localparam int IW = WORDS > 1 ? $clog2(WORDS) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t r_state;
  logic r_rr, r_c;
  logic [IW-1:0] r_idx;
  logic [W-1:0] r_a, r_b;
  logic w_any, w_gnt, w_run, w_ci, w_c0, w_sub;
  logic [N-1:0] w_wa, w_wb;
  assign w_any = |req_valid;
  assign w_gnt = &req_valid ? r_rr : req_valid[1];
  assign w_run = r_state == RUN;
  assign w_ci = w_gnt ? req1_ci : req0_ci;
`ifdef ADDSEQ_SUB_EN
  logic r_sub, w_sub_in;
  assign w_sub_in = w_gnt ? req1_sub : req0_sub;
  assign w_sub = r_sub;
  // subtract is A + ~B + 1, so the caller's carry-in is overridden
  assign w_c0 = w_sub_in | w_ci;
  always_ff @(posedge clk)
    if (rst) r_sub <= 1'b0;
    else if (r_state == IDLE && w_any) r_sub <= w_sub_in;
`else
  assign w_sub = 1'b0;
  assign w_c0 = w_ci;
`endif
  assign w_wa = r_a[r_idx*N +: N];
  assign w_wb = r_b[r_idx*N +: N];
  assign req_ready = (r_state == IDLE && !rst && w_any) ? (w_gnt ? 2'b10 : 2'b01) : 2'b00;
  assign resp_valid = r_state == DONE;
  assign add_a = w_run ? w_wa : '0;
  assign add_b = w_run ? (w_wb ^ {N{w_sub}}) : '0;
  assign add_ci = w_run ? r_c : 1'b0;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_rr <= 1'b0;
      r_idx <= '0;
      r_c <= 1'b0;
      r_a <= '0;
      r_b <= '0;
      resp_sum <= '0;
      resp_co <= 1'b0;
      resp_id <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_any) begin
          r_state <= RUN;
          r_idx <= '0;
          resp_id <= w_gnt;
          r_a <= w_gnt ? req1_a : req0_a;
          r_b <= w_gnt ? req1_b : req0_b;
          r_c <= w_c0;
          if (&req_valid) r_rr <= ~w_gnt;
        end
        RUN: begin
          resp_sum[r_idx*N +: N] <= add_s;
          r_c <= add_co;
          r_idx <= r_idx + 1'b1;
          if (r_idx == IW'(WORDS - 1)) begin
            resp_co <= add_co;
            r_state <= DONE;
          end
        end
        DONE: if (resp_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adder_seq_arbiter.sv
// tb_adder_seq_arbiter: vector table, directed corner sequences and random ops
// against an arithmetic reference model; the shared adder is modelled here.
module tb_adder_seq_arbiter;
  logic clk = 0, rst = 1;
  logic [1:0] req_valid = 0, req_ready;
  logic [15:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0, resp_sum;
  logic req0_ci = 0, req1_ci = 0, add_ci, add_co, resp_valid, resp_ready = 1, resp_id, resp_co;
  logic [3:0] add_a, add_b, add_s;
`ifdef ADDSEQ_SUB_EN
  logic req0_sub = 0, req1_sub = 0;
`endif
  int errs = 0, checks = 0;

  always #5 clk = ~clk;
  assign {add_co, add_s} = 5'(add_a) + 5'(add_b) + 5'(add_ci);

  adder_seq_arbiter #(.N(4), .WORDS(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_ci(req0_ci),
    .req1_a(req1_a), .req1_b(req1_b), .req1_ci(req1_ci),
`ifdef ADDSEQ_SUB_EN
    .req0_sub(req0_sub), .req1_sub(req1_sub),
`endif
    .add_a(add_a), .add_b(add_b), .add_ci(add_ci), .add_s(add_s), .add_co(add_co),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_sum(resp_sum), .resp_co(resp_co));

  typedef struct {
    logic id;
    logic [15:0] a, b;
    logic ci, sub;
    logic [15:0] sum;
    logic co;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [16:0] model(input logic [15:0] a, b, input logic ci, sub);
    logic [16:0] bb = sub ? 17'(~b) : 17'(b);
    return 17'(a) + bb + 17'(sub | ci);
  endfunction

  function automatic logic [3:0] model_cin(input logic [15:0] a, b, input logic ci, sub);
    logic [3:0] r;
    logic [31:0] bb = sub ? 32'(~b) : 32'(b);
    for (int k = 0; k < 4; k++) begin
      logic [31:0] m = (32'd1 << (4 * k)) - 1;
      r[k] = 1'(((32'(a) & m) + (bb & m) + 32'(sub | ci)) >> (4 * k));
    end
    return r;
  endfunction

  task automatic set_req(input logic id, input logic [15:0] a, b, input logic ci, sub);
    if (id) begin req1_a = a; req1_b = b; req1_ci = ci; end
    else begin req0_a = a; req0_b = b; req0_ci = ci; end
`ifdef ADDSEQ_SUB_EN
    if (id) req1_sub = sub; else req0_sub = sub;
`else
    if (sub) $display("sub requested without ADDSEQ_SUB_EN");
`endif
    req_valid[id] = 1'b1;
  endtask

  task automatic accept(input logic id);
    int n = 0;
    while (!req_ready[id] && n < 20) begin @(negedge clk); #1; n++; end
    chk("accept", 64'(req_ready), id ? 64'd2 : 64'd1);
  endtask

  // called in the accept cycle; releases the request and checks the response
  task automatic finish(input logic id, input logic [15:0] a, b, input logic ci, sub,
                        input logic [15:0] es, input logic eco);
    int lat = 1;
    logic [3:0] seen = 0;
    @(negedge clk); req_valid[id] = 1'b0; #1;
    while (!resp_valid && lat < 20) begin
      if (lat <= 4) seen[lat-1] = add_ci;
      @(negedge clk); #1; lat++;
    end
    chk("latency", 64'(lat), 64'd5);
    chk("sum", 64'(resp_sum), 64'(es));
    chk("co", 64'(resp_co), 64'(eco));
    chk("id", 64'(resp_id), 64'(id));
    chk("word_cin", 64'(seen), 64'(model_cin(a, b, ci, sub)));
  endtask

  task automatic op(input logic id, input logic [15:0] a, b, input logic ci, sub,
                    input logic [15:0] es, input logic eco);
    @(negedge clk); set_req(id, a, b, ci, sub); #1;
    accept(id);
    finish(id, a, b, ci, sub, es, eco);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[$];
    logic [16:0] m;
    logic [3:0] gseq;
    int ng, nr, n;
    tbl.push_back('{0, 16'h1234, 16'h0FFF, 0, 0, 16'h2233, 0});
    tbl.push_back('{0, 16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1});
    tbl.push_back('{1, 16'h8000, 16'h8000, 1, 0, 16'h0001, 1});
    tbl.push_back('{1, 16'h0000, 16'h0000, 1, 0, 16'h0001, 0});
    tbl.push_back('{0, 16'hABCD, 16'h5432, 0, 0, 16'hFFFF, 0});
`ifdef ADDSEQ_SUB_EN
    tbl.push_back('{0, 16'h0005, 16'h0007, 0, 1, 16'hFFFE, 0});
    tbl.push_back('{1, 16'h0007, 16'h0005, 0, 1, 16'h0002, 1});
`endif
    repeat (2) @(negedge clk);
    #1;
    chk("reset_outputs", {req_ready, resp_valid, resp_sum, resp_co, resp_id, add_a, add_b, add_ci}, 0);
    @(negedge clk); rst = 0;

    foreach (tbl[i]) op(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].sub, tbl[i].sum, tbl[i].co);

    // both requesters held valid: grants must alternate starting at requester 0
    @(negedge clk);
    set_req(0, 16'h1111, 16'h2222, 0, 0);
    set_req(1, 16'h0F0F, 16'h0101, 1, 0);
    ng = 0; nr = 0; gseq = 0; n = 0;
    while (n < 60) begin
      #1;
      if (req_ready != 0) begin
        if (ng < 4) gseq[ng] = req_ready[1];
        ng++;
      end
      if (resp_valid) begin
        chk("alt_id", 64'(resp_id), 64'(gseq[nr]));
        chk("alt_sum", 64'(resp_sum), resp_id ? 64'h1011 : 64'h3333);
        nr++;
      end
      if (nr == 4) break;
      @(negedge clk); n++;
    end
    req_valid = 0;
    chk("alt_responses", 64'(nr), 64'd4);
    chk("alt_grants", 64'(gseq), 64'b1010);

    // consumer stalls in DONE while another request waits
    @(negedge clk);
    resp_ready = 0;
    set_req(0, 16'h00F0, 16'h0F10, 0, 0); #1;
    accept(0);
    set_req(1, 16'h0001, 16'h0002, 0, 0);
    finish(0, 16'h00F0, 16'h0F10, 0, 0, 16'h1000, 0);
    repeat (3) begin
      @(negedge clk); #1;
      chk("hold", {req_ready, resp_valid, resp_sum, resp_co}, {2'b00, 1'b1, 16'h1000, 1'b0});
    end
    resp_ready = 1;
    n = 0;
    while (req_ready == 0 && n < 10) begin @(negedge clk); #1; n++; end
    chk("regrant_delay", 64'(n), 64'd1);
    accept(1);
    finish(1, 16'h0001, 16'h0002, 0, 0, 16'h0003, 0);

    // reset asserted during the second RUN cycle discards the op
    @(negedge clk);
    set_req(1, 16'hF00F, 16'h0FF1, 1, 0); #1;
    accept(1);
    @(negedge clk); req_valid = 0;
    @(negedge clk); rst = 1;
    @(negedge clk); #1;
    chk("mid_reset", {req_ready, resp_valid, resp_sum, resp_co, resp_id, add_a, add_b, add_ci}, 0);
    rst = 0;
    op(0, 16'h0F0F, 16'h00F1, 0, 0, 16'h1000, 0);

    for (int i = 0; i < 24; i++) begin
      logic id, ci, sub;
      logic [15:0] a, b;
      id = 1'($urandom); ci = 1'($urandom); a = 16'($urandom); b = 16'($urandom);
`ifdef ADDSEQ_SUB_EN
      sub = 1'($urandom);
`else
      sub = 0;
`endif
      m = model(a, b, ci, sub);
      op(id, a, b, ci, sub, m[15:0], m[16]);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
